// File: rtl/rocc_pkg.sv
// Shared RoCC command types: instruction field layout, command bundle and funct codes.
package rocc_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic [6:0] {
        FUNCT_WRITE = 7'd0,
        FUNCT_LOAD  = 7'd2,
        FUNCT_ACCUM = 7'd3
    } rocc_funct_e;

    typedef struct packed {
        logic [6:0] funct;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic       xd;
        logic       xs1;
        logic       xs2;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rocc_inst_t;

    typedef struct packed {
        rocc_inst_t      inst;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } rocc_cmd_t;

endpackage

// File: rtl/rocc_cmd_queue_ctrl.sv
// Head/tail pointers, maybe_full flag and occupancy count for the RoCC command queue.
module rocc_queue_ctrl
    import rocc_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             do_enq_i,
    input  logic             do_deq_i,
    output logic [PTR_W-1:0] head_o,
    output logic [PTR_W-1:0] tail_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             maybe_full_q, maybe_full_d;
    logic [PTR_W-1:0] ptr_diff;
    logic             ptr_match;

    assign ptr_match = (head_q == tail_q);
    assign empty_o   = ptr_match & ~maybe_full_q;
    assign full_o    = ptr_match & maybe_full_q;
    assign head_o    = head_q;
    assign tail_o    = tail_q;

    // DEPTH is a power of two, so the pointer difference wraps modulo DEPTH on its own.
    assign ptr_diff  = tail_q - head_q;
    assign count_o   = full_o ? CNT_W'(DEPTH) : CNT_W'(ptr_diff);

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        maybe_full_d = maybe_full_q;
        if (do_enq_i) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (do_deq_i) begin
            head_d = head_q + PTR_W'(1);
        end
        if (do_enq_i != do_deq_i) begin
            maybe_full_d = do_enq_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            maybe_full_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            maybe_full_q <= maybe_full_d;
        end
    end

endmodule

// File: rtl/rocc_cmd_queue.sv
// RoCC command queue: DEPTH-entry circular FIFO of {inst, rs1, rs2} commands.
// Define ROCC_CMD_QUEUE_FLOW_EN for zero-latency pass-through when the queue is empty.
module rocc_cmd_queue
    import rocc_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         io_enq_valid,
    output logic                         io_enq_ready,
    input  logic [31:0]                  io_enq_bits_inst,
    input  logic [63:0]                  io_enq_bits_rs1,
    input  logic [63:0]                  io_enq_bits_rs2,
    input  logic                         io_deq_ready,
    output logic                         io_deq_valid,
    output logic [31:0]                  io_deq_bits_inst,
    output logic [63:0]                  io_deq_bits_rs1,
    output logic [63:0]                  io_deq_bits_rs2,
    output logic [$clog2(DEPTH+1)-1:0]   io_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    rocc_cmd_t        mem_q [DEPTH];
    rocc_cmd_t        enq_cmd;
    rocc_cmd_t        deq_cmd;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             empty;
    logic             full;
    logic             do_enq;
    logic             do_deq;

    assign enq_cmd      = {io_enq_bits_inst, io_enq_bits_rs1, io_enq_bits_rs2};
    assign io_enq_ready = ~full;

`ifdef ROCC_CMD_QUEUE_FLOW_EN
    // An empty queue forwards the offered command; if it is consumed at once, nothing is stored.
    assign io_deq_valid = ~empty | io_enq_valid;
    assign deq_cmd      = empty ? enq_cmd : mem_q[head];
    assign do_enq       = io_enq_valid & ~full & ~(empty & io_deq_ready);
    assign do_deq       = io_deq_ready & ~empty;
`else
    assign io_deq_valid = ~empty;
    assign deq_cmd      = mem_q[head];
    assign do_enq       = io_enq_valid & ~full;
    assign do_deq       = io_deq_ready & ~empty;
`endif

    assign io_deq_bits_inst = deq_cmd.inst;
    assign io_deq_bits_rs1  = deq_cmd.rs1;
    assign io_deq_bits_rs2  = deq_cmd.rs2;

    rocc_queue_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .do_enq_i (do_enq),
        .do_deq_i (do_deq),
        .head_o   (head),
        .tail_o   (tail),
        .empty_o  (empty),
        .full_o   (full),
        .count_o  (io_count)
    );

    // Storage is intentionally not reset; a write coincident with reset is orphaned by the pointer reset.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem_q[tail] <= enq_cmd;
        end
    end

endmodule

// File: tb/tb_rocc_cmd_queue.sv
// Self-checking bench for rocc_cmd_queue: directed scenarios plus randomized traffic against a queue model.
module tb_rocc_cmd_queue;
    import rocc_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef ROCC_CMD_QUEUE_FLOW_EN
    localparam bit FLOW = 1'b1;
`else
    localparam bit FLOW = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             io_enq_valid;
    logic             io_enq_ready;
    logic [31:0]      io_enq_bits_inst;
    logic [63:0]      io_enq_bits_rs1;
    logic [63:0]      io_enq_bits_rs2;
    logic             io_deq_ready;
    logic             io_deq_valid;
    logic [31:0]      io_deq_bits_inst;
    logic [63:0]      io_deq_bits_rs1;
    logic [63:0]      io_deq_bits_rs2;
    logic [CNT_W-1:0] io_count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          armed   = 1'b0;
    logic [159:0] mdl [$];

    rocc_cmd_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .io_enq_valid     (io_enq_valid),
        .io_enq_ready     (io_enq_ready),
        .io_enq_bits_inst (io_enq_bits_inst),
        .io_enq_bits_rs1  (io_enq_bits_rs1),
        .io_enq_bits_rs2  (io_enq_bits_rs2),
        .io_deq_ready     (io_deq_ready),
        .io_deq_valid     (io_deq_valid),
        .io_deq_bits_inst (io_deq_bits_inst),
        .io_deq_bits_rs1  (io_deq_bits_rs1),
        .io_deq_bits_rs2  (io_deq_bits_rs2),
        .io_count         (io_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        rocc_inst_t  i;
        int unsigned sel;
        i   = rocc_inst_t'($urandom);
        sel = $urandom_range(0, 2);
        i.funct = (sel == 0) ? FUNCT_WRITE : (sel == 1) ? FUNCT_LOAD : FUNCT_ACCUM;
        return i;
    endfunction

    task automatic drive(input logic ev, input logic dr, input logic [63:0] r1);
        io_enq_valid     = ev;
        io_deq_ready     = dr;
        io_enq_bits_rs1  = r1;
        io_enq_bits_inst = rand_inst();
        io_enq_bits_rs2  = {$urandom, $urandom};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: occupancy is the queue size; head is the oldest element.
    always @(posedge clk) begin
        int unsigned sz;
        bit enq_fire, deq_fire;
        if (reset) begin
            mdl.delete();
            armed = 1'b1;
        end else if (armed) begin
            sz       = mdl.size();
            enq_fire = io_enq_valid && (sz < DEPTH);
            deq_fire = io_deq_ready && ((sz > 0) || (FLOW && io_enq_valid));
            if (!(FLOW && sz == 0 && enq_fire && deq_fire)) begin
                if (deq_fire && sz > 0) void'(mdl.pop_front());
                if (enq_fire) mdl.push_back({io_enq_bits_inst, io_enq_bits_rs1, io_enq_bits_rs2});
            end
        end
    end

    always @(negedge clk) begin
        int unsigned sz;
        logic         exp_valid;
        logic [159:0] exp_bits;
        if (armed) begin
            sz        = mdl.size();
            exp_valid = (sz > 0) || (FLOW && io_enq_valid);
            chk("count", 160'(io_count), 160'(sz));
            chk("enq_ready", 160'(io_enq_ready), 160'(sz < DEPTH));
            chk("deq_valid", 160'(io_deq_valid), 160'(exp_valid));
            if (exp_valid) begin
                exp_bits = (sz > 0) ? mdl[0] : {io_enq_bits_inst, io_enq_bits_rs1, io_enq_bits_rs2};
                chk("deq_bits", {io_deq_bits_inst, io_deq_bits_rs1, io_deq_bits_rs2}, exp_bits);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 64'h0);
        tick();
        tick();
        reset = 1'b0;
        #2;
        chk("rst_enq_ready", 160'(io_enq_ready), 160'd1);
        chk("rst_deq_valid", 160'(io_deq_valid), 160'd0);
        chk("rst_count", 160'(io_count), 160'd0);

        // Fill to DEPTH with the consumer stalled, then offer a third command.
        drive(1'b1, 1'b0, 64'h11); tick();
        drive(1'b1, 1'b0, 64'h22); tick();
        drive(1'b1, 1'b0, 64'h33); #2;
        chk("full_count", 160'(io_count), 160'd2);
        chk("full_enq_ready", 160'(io_enq_ready), 160'd0);
        chk("full_head", 160'(io_deq_bits_rs1), 160'h11);
        tick(); #2;
        chk("held_count", 160'(io_count), 160'd2);

        // Full with both sides active: only the dequeue fires.
        drive(1'b1, 1'b1, 64'h33); #2;
        chk("nopipe_enq_ready", 160'(io_enq_ready), 160'd0);
        chk("nopipe_out", 160'(io_deq_bits_rs1), 160'h11);
        tick(); #2;
        chk("after_deq_count", 160'(io_count), 160'd1);
        chk("after_deq_head", 160'(io_deq_bits_rs1), 160'h22);
        drive(1'b1, 1'b0, 64'h33); tick();
        drive(1'b0, 1'b1, 64'h0); #2;
        chk("order_a", 160'(io_deq_bits_rs1), 160'h22);
        tick(); #2;
        chk("order_b", 160'(io_deq_bits_rs1), 160'h33);
        chk("order_count", 160'(io_count), 160'd1);

        // Steady enq+deq with one entry resident; pointers wrap several times.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 64'(i)); #2;
            chk("stream_count", 160'(io_count), 160'd1);
            chk("stream_out", 160'(io_deq_bits_rs1), (i == 1) ? 160'h33 : 160'(i - 1));
            tick();
        end
        drive(1'b0, 1'b1, 64'h0); #2;
        chk("stream_last", 160'(io_deq_bits_rs1), 160'h8);
        tick(); #2;
        chk("drained_count", 160'(io_count), 160'd0);

        // Command offered to an empty queue with the consumer ready.
        drive(1'b1, 1'b1, 64'hAB); #2;
        if (FLOW) begin
            chk("flow_valid", 160'(io_deq_valid), 160'd1);
            chk("flow_rs1", 160'(io_deq_bits_rs1), 160'hAB);
            tick(); drive(1'b0, 1'b0, 64'h0); #2;
            chk("flow_count", 160'(io_count), 160'd0);
        end else begin
            chk("lat_valid", 160'(io_deq_valid), 160'd0);
            tick(); drive(1'b0, 1'b0, 64'h0); #2;
            chk("lat_count", 160'(io_count), 160'd1);
            chk("lat_rs1", 160'(io_deq_bits_rs1), 160'hAB);
            drive(1'b0, 1'b1, 64'h0); tick();
        end

        // Mid-operation reset discards contents and a coincident enqueue.
        drive(1'b1, 1'b0, 64'h55); tick();
        drive(1'b1, 1'b0, 64'h66); tick();
        reset = 1'b1;
        drive(1'b1, 1'b0, 64'h77); tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 64'h0); #2;
        chk("mid_rst_count", 160'(io_count), 160'd0);
        chk("mid_rst_valid", 160'(io_deq_valid), 160'd0);
        drive(1'b1, 1'b0, 64'h88); tick();
        drive(1'b0, 1'b0, 64'h0); #2;
        chk("post_rst_count", 160'(io_count), 160'd1);
        chk("post_rst_head", 160'(io_deq_bits_rs1), 160'h88);

        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, {$urandom, $urandom});
            tick();
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 64'h0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rocc_cmd_queue.md
ROCC_CMD_QUEUE -- requirements
Module: rocc_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of command entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port io_enq_valid  input  1  core offers a command.
REQ-005 SHALL have port io_enq_ready  output  1  queue accepts a command this cycle.
REQ-006 SHALL have port io_enq_bits_inst  input  32  {funct[7], rs2[5], rs1[5], xd, xs1, xs2, rd[5], opcode[7]}.
REQ-007 SHALL have port io_enq_bits_rs1  input  64  rs1 operand value.
REQ-008 SHALL have port io_enq_bits_rs2  input  64  rs2 operand value.
REQ-009 SHALL have port io_deq_ready  input  1  accumulator consumes head entry.
REQ-010 SHALL have port io_deq_valid  output  1  head entry present.
REQ-011 SHALL have ports io_deq_bits_inst/rs1/rs2  output  32/64/64  head entry, same packing as enq.
REQ-012 SHALL have port io_count  output  clog2(DEPTH+1)  occupied entries.

Function
REQ-013 SHALL store entries in a DEPTH-deep circular buffer addressed by head/tail pointers (clog2(DEPTH) bits, wrap DEPTH-1 -> 0) plus a maybe_full flag.
REQ-014 SHALL define empty = (head==tail)&!maybe_full; full = (head==tail)&maybe_full.
REQ-015 SHALL drive io_enq_ready = !full and io_deq_valid = !empty (base mode); enq fires on valid&ready, deq on valid&ready.
REQ-016 SHALL, on enq fire, write the entry at tail and advance tail; on deq fire, advance head.
REQ-017 SHALL set maybe_full when enq fires without deq, clear it when deq fires without enq, hold it when both or neither fire.
REQ-018 SHALL present an entry enqueued in cycle N on io_deq_* no earlier than cycle N+1 (base mode); io_deq_bits SHALL be the head entry, unchanged while io_deq_valid & !io_deq_ready.
REQ-019 SHALL keep io_enq_ready low when full even if io_deq_ready is high (no pipe-through).
REQ-020 SHALL, on simultaneous enq and deq with 0<count<DEPTH, perform both; io_count unchanged.
REQ-021 SHALL compute io_count = maybe_full&(head==tail) ? DEPTH : (tail-head) mod DEPTH, combinationally.
REQ-022 SHALL preserve FIFO order and all 160 entry bits exactly.

Reset
REQ-023 SHALL, while reset, force head=0, tail=0, maybe_full=0; outputs next cycle: io_enq_ready=1, io_deq_valid=0, io_count=0.
REQ-024 SHALL not reset storage contents; io_deq_bits undefined while io_deq_valid=0.
REQ-025 SHALL discard all queued commands on reset asserted mid-operation; an enq coincident with reset is dropped.

Configuration
REQ-026 SHALL, with ROCC_CMD_QUEUE_FLOW_EN defined, when empty: drive io_deq_valid=io_enq_valid and io_deq_bits=io_enq_bits combinationally; if io_deq_ready also high, not write storage and not move pointers (zero latency).
REQ-027 SHALL, without ROCC_CMD_QUEUE_FLOW_EN, behave per REQ-015/018 only (1-cycle minimum latency).

Structure
REQ-028 SHALL take rocc_cmd_t (inst/rs1/rs2 packed struct), rocc_inst_t field layout, XLEN=64 and funct codes (WRITE=0, LOAD=2, ACCUM=3) from shared package rocc_pkg.
REQ-029 SHALL place pointer, maybe_full and count logic in one sub-module rocc_queue_ctrl; data array inline.

Verification
REQ-030 SHALL verify: reset, then no stimulus -> io_enq_ready=1, io_deq_valid=0, io_count=0.
REQ-031 SHALL verify (DEPTH=2, base): enq rs1=0x11 then 0x22, deq_ready=0 -> count=2, enq_ready=0; third enq 0x33 held, not accepted.
REQ-032 SHALL verify: full, deq_ready=1 and enq_valid=1 same cycle -> only deq fires (0x11 out), count=1; next cycle 0x33 accepted, order 0x22,0x33.
REQ-033 SHALL verify: count=1, enq+deq fire together for 8 cycles with rs1=1..8 -> count stays 1, outputs in order, pointers wrap.
REQ-034 SHALL verify (FLOW_EN): empty, enq rs1=0xAB with deq_ready=1 -> deq_valid=1, rs1=0xAB same cycle, count stays 0.
REQ-035 SHALL verify: count=2, reset 1 cycle -> count=0, deq_valid=0; pre-reset entries never appear.
